// File: rtl/zf_h2s_packet_trim.sv
// Trims datamover MM2S buffers down to the CVITA packet length carried in the
// header word, regenerating tlast and silently draining any trailing padding.
module zf_h2s_packet_trim #(
    parameter int MAX_WORDS = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [63:0]          i_tdata,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [63:0]          o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic [CNT_WIDTH-1:0] short_count,
    output logic [CNT_WIDTH-1:0] clamp_count,
    output logic [CNT_WIDTH-1:0] drop_count
);

    localparam int REM_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        HEADER,
        BODY,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [REM_W-1:0] remaining;
    logic [REM_W-1:0] remaining_next;
    logic [16:0]      words_raw;
    logic [REM_W-1:0] words;
    logic             words_clamped;
    logic             beat;
    logic             short_inc;
    logic             clamp_inc;
    logic             drop_inc;

    // 17-bit rounding so a 0xFFFF byte length yields 8192 words, not a wrap.
    always_comb begin
        words_raw     = ({1'b0, i_tdata[47:32]} + 17'd7) >> 3;
        words_clamped = (words_raw > 17'(MAX_WORDS));
        if (words_clamped) begin
            words = REM_W'(MAX_WORDS);
        end else if (words_raw == 17'd0) begin
            words = REM_W'(1);
        end else begin
            words = REM_W'(words_raw);
        end
    end

    assign o_tdata = i_tdata;
    assign beat    = i_tvalid && i_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HEADER;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        o_tvalid       = 1'b0;
        o_tlast        = 1'b0;
        i_tready       = 1'b1;
        short_inc      = 1'b0;
        clamp_inc      = 1'b0;
        drop_inc       = 1'b0;
        case (state)
            HEADER: begin
                o_tvalid = i_tvalid;
                i_tready = o_tready;
                o_tlast  = i_tlast || (words == REM_W'(1));
                if (beat) begin
                    clamp_inc = words_clamped;
                    if (i_tlast) begin
                        short_inc = (words > REM_W'(1));
                    end else if (words == REM_W'(1)) begin
                        state_next = DRAIN;
                    end else begin
                        remaining_next = words - REM_W'(1);
                        state_next     = BODY;
                    end
                end
            end
            BODY: begin
                o_tvalid = i_tvalid;
                i_tready = o_tready;
                o_tlast  = i_tlast || (remaining == REM_W'(1));
                if (beat) begin
                    remaining_next = remaining - REM_W'(1);
                    if (i_tlast) begin
                        state_next = HEADER;
                        short_inc  = (remaining != REM_W'(1));
                    end else if (remaining == REM_W'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Padding is accepted unconditionally so it never waits on the consumer.
                if (beat) begin
                    drop_inc = 1'b1;
                    if (i_tlast) begin
                        state_next = HEADER;
                    end
                end
            end
            default: begin
                state_next = HEADER;
            end
        endcase
    end

    function automatic logic [CNT_WIDTH-1:0] sat_next(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 inc,
        input logic                 clr
    );
        if (clr) begin
            return '0;
        end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
            return cnt + CNT_WIDTH'(1);
        end
        return cnt;
    endfunction

    // Sticky saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            short_count <= '0;
            clamp_count <= '0;
            drop_count  <= '0;
        end else begin
            short_count <= sat_next(short_count, short_inc, clear);
            clamp_count <= sat_next(clamp_count, clamp_inc, clear);
            drop_count  <= sat_next(drop_count, drop_inc, clear);
        end
    end

endmodule

// File: tb/tb_zf_h2s_packet_trim.sv
// Directed and randomized-handshake checks of zf_h2s_packet_trim; dut_b uses
// MAX_WORDS=4 for the clamp case and shares the input bus with dut_a.
module tb_zf_h2s_packet_trim;

    logic        clk = 1'b0;
    logic        rst, clear;
    logic [63:0] i_tdata;
    logic        i_tlast, i_tvalid, o_tready;

    logic        a_i_tready, a_o_tlast, a_o_tvalid;
    logic [63:0] a_o_tdata;
    logic [15:0] a_short, a_clamp, a_drop;
    logic        b_i_tready, b_o_tlast, b_o_tvalid;
    logic [63:0] b_o_tdata;
    logic [15:0] b_short, b_clamp, b_drop;

    logic        sel = 1'b0;
    logic        m_i_tready, m_o_tlast, m_o_tvalid;
    logic [63:0] m_o_tdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    zf_h2s_packet_trim dut_a (
        .clk(clk), .rst(rst), .clear(clear),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(a_i_tready),
        .o_tdata(a_o_tdata), .o_tlast(a_o_tlast), .o_tvalid(a_o_tvalid), .o_tready(o_tready),
        .short_count(a_short), .clamp_count(a_clamp), .drop_count(a_drop)
    );

    zf_h2s_packet_trim #(.MAX_WORDS(4), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .clear(clear),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(b_i_tready),
        .o_tdata(b_o_tdata), .o_tlast(b_o_tlast), .o_tvalid(b_o_tvalid), .o_tready(o_tready),
        .short_count(b_short), .clamp_count(b_clamp), .drop_count(b_drop)
    );

    assign m_i_tready = sel ? b_i_tready : a_i_tready;
    assign m_o_tlast  = sel ? b_o_tlast  : a_o_tlast;
    assign m_o_tvalid = sel ? b_o_tvalid : a_o_tvalid;
    assign m_o_tdata  = sel ? b_o_tdata  : a_o_tdata;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [15:0] len);
        return {16'hA5A5, len, 32'h1234_5678};
    endfunction

    function automatic logic [63:0] body(input int pkt, input int idx);
        return {16'hBEEF, 16'(pkt), 32'(idx)};
    endfunction

    // One beat with i_tvalid=1; rdy=0 is only used on beats expected to be drained.
    task automatic applyStimulus(input logic [63:0] d, input logic l, input logic rdy,
                                 input logic ev, input logic el, input string tag);
        @(negedge clk);
        i_tvalid = 1'b1;
        i_tdata  = d;
        i_tlast  = l;
        o_tready = rdy;
        #1;
        checkOutput({tag, ".valid"}, 64'(m_o_tvalid), 64'(ev));
        checkOutput({tag, ".ready"}, 64'(m_i_tready), ev ? 64'(rdy) : 64'd1);
        if (ev) begin
            checkOutput({tag, ".last"}, 64'(m_o_tlast), 64'(el));
            checkOutput({tag, ".data"}, m_o_tdata, d);
        end
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulseClear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic checkCounters(input string tag, input int s, input int c, input int d);
        checkOutput({tag, ".short"}, 64'(a_short), 64'(s));
        checkOutput({tag, ".clamp"}, 64'(a_clamp), 64'(c));
        checkOutput({tag, ".drop"},  64'(a_drop),  64'(d));
    endtask

    logic [63:0] in_d[$];
    logic        in_l[$];
    logic [63:0] ex_d[$];
    logic        ex_l[$];

    initial begin
        int pads;
        int cyc;
        logic fire;

        rst = 1'b1; clear = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0;
        i_tdata = '0; o_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkCounters("reset", 0, 0, 0);

        // Backpressure passes straight through in HEADER
        @(negedge clk);
        o_tready = 1'b0; i_tvalid = 1'b1; i_tdata = hdr(16'd32);
        #1;
        checkOutput("bp.ready", 64'(a_i_tready), 64'd0);
        checkOutput("bp.valid", 64'(a_o_tvalid), 64'd1);
        @(negedge clk);
        i_tvalid = 1'b0; o_tready = 1'b1;

        // Exact fit: len=32 -> 4 words
        applyStimulus(hdr(16'd32), 1'b0, 1'b1, 1'b1, 1'b0, "fit0");
        applyStimulus(body(1, 1),  1'b0, 1'b1, 1'b1, 1'b0, "fit1");
        applyStimulus(body(1, 2),  1'b0, 1'b1, 1'b1, 1'b0, "fit2");
        applyStimulus(body(1, 3),  1'b1, 1'b1, 1'b1, 1'b1, "fit3");
        checkCounters("fit", 0, 0, 0);

        // Padded: len=20 -> 3 words, 5 padding beats
        applyStimulus(hdr(16'd20), 1'b0, 1'b1, 1'b1, 1'b0, "pad0");
        applyStimulus(body(2, 1),  1'b0, 1'b1, 1'b1, 1'b0, "pad1");
        applyStimulus(body(2, 2),  1'b0, 1'b1, 1'b1, 1'b1, "pad2");
        applyStimulus(body(2, 3),  1'b0, 1'b0, 1'b0, 1'b0, "pad3");
        applyStimulus(body(2, 4),  1'b0, 1'b1, 1'b0, 1'b0, "pad4");
        applyStimulus(body(2, 5),  1'b0, 1'b0, 1'b0, 1'b0, "pad5");
        applyStimulus(body(2, 6),  1'b0, 1'b1, 1'b0, 1'b0, "pad6");
        applyStimulus(body(2, 7),  1'b1, 1'b1, 1'b0, 1'b0, "pad7");
        checkCounters("pad", 0, 0, 5);

        // Short: len=64 -> 8 words, buffer ends after 3
        applyStimulus(hdr(16'd64), 1'b0, 1'b1, 1'b1, 1'b0, "short0");
        applyStimulus(body(3, 1),  1'b0, 1'b1, 1'b1, 1'b0, "short1");
        applyStimulus(body(3, 2),  1'b1, 1'b1, 1'b1, 1'b1, "short2");
        checkCounters("short", 1, 0, 5);

        // Single word with tlast on the header
        applyStimulus(hdr(16'd4), 1'b1, 1'b1, 1'b1, 1'b1, "one");
        checkCounters("one", 1, 0, 5);

        // len=0 is treated as one word
        applyStimulus(hdr(16'd0), 1'b0, 1'b1, 1'b1, 1'b1, "zero0");
        applyStimulus(body(5, 1), 1'b1, 1'b1, 1'b0, 1'b0, "zero1");
        checkCounters("zero", 1, 0, 6);

        // Clamp on the MAX_WORDS=4 instance
        pulseReset();
        sel = 1'b1;
        applyStimulus(hdr(16'hFFFF), 1'b0, 1'b1, 1'b1, 1'b0, "clamp0");
        applyStimulus(body(6, 1),    1'b0, 1'b1, 1'b1, 1'b0, "clamp1");
        applyStimulus(body(6, 2),    1'b0, 1'b1, 1'b1, 1'b0, "clamp2");
        applyStimulus(body(6, 3),    1'b0, 1'b1, 1'b1, 1'b1, "clamp3");
        applyStimulus(body(6, 4),    1'b0, 1'b1, 1'b0, 1'b0, "clamp4");
        applyStimulus(body(6, 5),    1'b1, 1'b1, 1'b0, 1'b0, "clamp5");
        checkOutput("clamp.clamp", 64'(b_clamp), 64'd1);
        checkOutput("clamp.drop",  64'(b_drop),  64'd2);
        checkOutput("clamp.short", 64'(b_short), 64'd0);
        sel = 1'b0;

        // Randomized handshakes over 1000 padded buffers
        pulseReset();
        pads = 0;
        for (int p = 0; p < 1000; p++) begin
            int len, w, pad, n;
            len = $urandom_range(1, 48);
            w   = (len + 7) / 8;
            pad = $urandom_range(0, 3);
            n   = w + pad;
            pads += pad;
            for (int b = 0; b < n; b++) begin
                logic [63:0] d;
                d = (b == 0) ? hdr(16'(len)) : body(p, b);
                in_d.push_back(d);
                in_l.push_back(b == n - 1);
                if (b < w) begin
                    ex_d.push_back(d);
                    ex_l.push_back(b == w - 1);
                end
            end
        end
        cyc = 0;
        while (in_d.size() > 0 && cyc < 50000) begin
            @(negedge clk);
            i_tvalid = ($urandom_range(0, 3) != 0);
            i_tdata  = in_d[0];
            i_tlast  = in_l[0];
            o_tready = ($urandom_range(0, 3) != 0);
            #1;
            if (a_o_tvalid && o_tready) begin
                if (ex_d.size() == 0) begin
                    checkOutput("stress.extra", 64'd1, 64'd0);
                end else begin
                    checkOutput("stress.data", a_o_tdata, ex_d[0]);
                    checkOutput("stress.last", 64'(a_o_tlast), 64'(ex_l[0]));
                    void'(ex_d.pop_front());
                    void'(ex_l.pop_front());
                end
            end
            fire = i_tvalid && a_i_tready;
            @(posedge clk);
            if (fire) begin
                void'(in_d.pop_front());
                void'(in_l.pop_front());
            end
            cyc++;
        end
        @(negedge clk);
        i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b1;
        checkOutput("stress.inputs_left", 64'(in_d.size()), 64'd0);
        checkOutput("stress.outputs_left", 64'(ex_d.size()), 64'd0);
        checkCounters("stress", 0, 0, pads);

        pulseClear();
        checkCounters("clear", 0, 0, 0);

        // Reset in BODY: next beat must be parsed as a header
        applyStimulus(hdr(16'd64), 1'b0, 1'b1, 1'b1, 1'b0, "mid0");
        applyStimulus(body(7, 1),  1'b0, 1'b1, 1'b1, 1'b0, "mid1");
        pulseReset();
        applyStimulus(hdr(16'd8),  1'b0, 1'b1, 1'b1, 1'b1, "rst0");
        applyStimulus(body(8, 1),  1'b1, 1'b1, 1'b0, 1'b0, "rst1");
        checkCounters("rst", 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zf_h2s_packet_trim.md
Name: zf_h2s_packet_trim

Overview:
- Sits between the datamover MM2S stream output and the host-to-stream (h2s) consumer.
- The datamover reads fixed-size DDR buffers, so a buffer can carry padding past the end of the packet.
- This block parses the CVITA header in the first beat, regenerates tlast at the true packet end, and silently drains the padding beats up to the input tlast.
- Sticky counters report malformed buffers to software via readback.

Parameters:
- MAX_WORDS, 1024: maximum output packet length in 64-bit words. Longer header lengths are clamped to this value.
- CNT_WIDTH, 16: width of each status counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- clear  in  1  synchronous clear of all status counters
- i_tdata  in  64  datamover stream data; word 0 carries the CVITA header in [63:32], length in bytes in [47:32]
- i_tlast  in  1  end of buffer
- i_tvalid  in  1
- i_tready  out  1
- o_tdata  out  64  trimmed packet data
- o_tlast  out  1  true end of packet
- o_tvalid  out  1
- o_tready  in  1
- short_count  out  CNT_WIDTH  buffers whose i_tlast arrived before the header length was reached
- clamp_count  out  CNT_WIDTH  headers with length above MAX_WORDS
- drop_count  out  CNT_WIDTH  padding beats discarded

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=HEADER, remaining=0, all counters 0.
- Combinational outputs: o_tvalid, o_tready-derived i_tready and o_tlast are combinational from state and inputs. There are no registers on the data path and latency is 0 cycles. o_tdata=i_tdata always.
- Beat definition: a beat transfers on i_tvalid&&i_tready.
- Word count: words = (len+7)>>3, computed in 17-bit arithmetic so len=0xFFFF gives 8192.
  - If words==0, words=1.
  - If words>MAX_WORDS, words=MAX_WORDS and clamp_count increments.
- State HEADER:
  - o_tvalid=i_tvalid; i_tready=o_tready.
  - o_tlast = i_tlast || (words==1).
  - On a beat:
    - If i_tlast: stay in HEADER. If words>1, also short_count++.
    - Else if words==1: go to DRAIN.
    - Else: remaining=words-1 and go to BODY.
- State BODY:
  - o_tvalid=i_tvalid; i_tready=o_tready.
  - o_tlast = i_tlast || (remaining==1).
  - On a beat:
    - remaining decrements.
    - If i_tlast: go to HEADER. If remaining!=1, also short_count++.
    - Else if remaining==1: go to DRAIN.
- State DRAIN:
  - o_tvalid=0; i_tready=1, so padding never stalls on the consumer.
  - Every beat increments drop_count.
  - The beat with i_tlast returns to HEADER.
- Counter behaviour: counters saturate at all-ones.
  - clear has priority over an increment in the same cycle.
  - rst clears all counters.
- Reset mid-packet: returns to HEADER immediately. The next accepted beat is treated as a header even if the datamover is mid-buffer. Software is responsible for resetting the datamover together with this block.
- Backpressure:
  - In HEADER/BODY, i_tready must follow o_tready with no bubble.
  - o_tvalid must not depend on o_tready.

Test Plan:
- Exact-fit buffer: header len=32, 4 beats, i_tlast on beat 4 -> 4 output beats, o_tlast on beat 4, all counters 0.
- Padded buffer: len=20, 8 input beats -> 3 output beats, o_tlast on beat 3, beats 4-8 consumed with o_tvalid=0, drop_count=5, next header accepted on the following beat.
- Short buffer: len=64, i_tlast on beat 3 -> 3 output beats, o_tlast on beat 3, short_count=1, state back to HEADER.
- Single-word cases:
  - len=4 with i_tlast on beat 1 -> 1 beat, o_tlast=1, no drops.
  - len=0 with 2 input beats -> 1 output beat, drop_count=1.
- Clamp: MAX_WORDS=4, len=0xFFFF, 6 input beats -> 4 output beats, o_tlast on beat 4, clamp_count=1, drop_count=2.
- Stress: random o_tready and i_tvalid toggling over 1000 padded packets -> output matches the scoreboard-trimmed stream, no beat duplicated or lost. Then assert rst mid-BODY -> next beat treated as header; assert clear -> counters read 0.
